// File: rtl/timer_pkg.sv
// Register map, control/status bit positions and FSM states shared by the bus timer.
package timer_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_LOAD     = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int STAT_FLAG = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for the bus timer: one tick every div+1 enabled clocks.
module timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with auto-reload and level interrupt.
// Optional 8-bit prescaler at offset 0x10 when BUS_TIMER_PRESCALE_EN is defined.
module bus_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  output logic        intimer
);

  state_e      state_q, state_d;
  logic        auto_q, auto_d;
  logic        ie_q, ie_d;
  logic        flag_q, flag_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;

  logic        wr, ctrl_wr, stop, tick, pre_clr;
  logic [2:0]  off;
  logic        unused_addr;

  assign wr          = ce & we;
  assign off         = addr[4:2];
  assign ctrl_wr     = wr && (off == OFF_CTRL);
  assign stop        = ctrl_wr && !wtData[CTRL_EN];
  assign unused_addr = ^{addr[31:5], addr[1:0]};

`ifdef BUS_TIMER_PRESCALE_EN
  logic [7:0] ps_q, ps_d;

  always_comb begin
    ps_d = ps_q;
    if (wr && (off == OFF_PRESCALE)) ps_d = wtData[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ps_q <= '0;
    else      ps_q <= ps_d;
  end

  timer_prescaler u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (state_q == RUN),
    .div  (ps_q),
    .tick (tick)
  );
`else
  assign tick = (state_q == RUN);
`endif

  always_comb begin
    state_d = state_q;
    auto_d  = auto_q;
    ie_d    = ie_q;
    flag_d  = flag_q;
    load_d  = load_q;
    count_d = count_q;
    pre_clr = 1'b0;

    // A stop write freezes COUNT, so it must pre-empt this edge's tick.
    if (tick && !stop) begin
      if (count_q != '0)  count_d = count_q - 32'd1;
      else if (auto_q)    count_d = load_q;
      else                state_d = IDLE;
    end

    if (ctrl_wr) begin
      auto_d = wtData[CTRL_AUTO];
      ie_d   = wtData[CTRL_IE];
      if (wtData[CTRL_EN] && (state_q == IDLE)) begin
        state_d = RUN;
        count_d = load_q;
        pre_clr = 1'b1;
      end else if (!wtData[CTRL_EN]) begin
        state_d = IDLE;
      end
    end

    if (wr && (off == OFF_LOAD)) begin
      load_d = wtData;
      if (state_q == IDLE) count_d = wtData;
    end

    if (wr && (off == OFF_STATUS) && wtData[STAT_FLAG]) flag_d = 1'b0;
    // Expiry sets after the clear so a same-edge W1C loses.
    if (tick && !stop && (count_q == '0)) flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      flag_q  <= 1'b0;
      load_q  <= RESET_LOAD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      flag_q  <= flag_d;
      load_q  <= load_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    rdData = '0;
    if (ce && !we) begin
      case (off)
        OFF_CTRL:     rdData = {29'd0, ie_q, auto_q, state_q == RUN};
        OFF_LOAD:     rdData = load_q;
        OFF_COUNT:    rdData = count_q;
        OFF_STATUS:   rdData = {31'd0, flag_q};
`ifdef BUS_TIMER_PRESCALE_EN
        OFF_PRESCALE: rdData = {24'd0, ps_q};
`endif
        default:      rdData = '0;
      endcase
    end
  end

  assign intimer = flag_q & ie_q;

endmodule

// File: tb/tb_bus_timer.sv
// Randomized + directed bench for bus_timer against a behavioural register model.
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr, wtData;
  logic [31:0] rdData;
  logic        intimer;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic        m_en, m_auto, m_ie, m_flag;
  logic [31:0] m_load, m_cnt;

  bus_timer dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .addr   (addr),
    .wtData (wtData),
    .rdData (rdData),
    .intimer(intimer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_flag = 0;
    m_load = 32'hFFFF_FFFF; m_cnt = 0;
  endtask

  function automatic logic [31:0] m_rd(input logic c, input logic w, input logic [31:0] a);
    if (!c || w) return 32'h0;
    case (a[4:2])
      3'd0:    return {29'd0, m_ie, m_auto, m_en};
      3'd1:    return m_load;
      3'd2:    return m_cnt;
      3'd3:    return {31'd0, m_flag};
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the register model, applied to the bus inputs present at that edge.
  task automatic m_step(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic wr, set, en0;
    logic [2:0] off;
    logic [31:0] ld0;
    wr = c && w; off = a[4:2]; en0 = m_en; ld0 = m_load; set = 0;
    if (en0 && !(wr && off == 3'd0 && !d[0])) begin
      if (m_cnt != 0) m_cnt = m_cnt - 1;
      else begin
        set = 1;
        if (m_auto) m_cnt = ld0; else m_en = 0;
      end
    end
    if (wr && off == 3'd0) begin
      m_auto = d[1]; m_ie = d[2];
      if (d[0] && !en0) begin m_en = 1; m_cnt = ld0; end
      else if (!d[0]) m_en = 0;
    end
    if (wr && off == 3'd1) begin m_load = d; if (!en0) m_cnt = d; end
    if (wr && off == 3'd3 && d[0]) m_flag = 0;
    if (set) m_flag = 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_rdData", rdData, m_rd(ce, we, addr));
      chk("cyc_intimer", {31'd0, intimer}, {31'd0, m_flag & m_ie});
    end
  end

  task automatic edge_();
    @(posedge clk);
    if (rst) m_step(ce, we, addr, wtData);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ce = 1; we = 1; addr = a; wtData = d;
    edge_();
    ce = 0; we = 0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    ce = 1; we = 0; addr = a;
    #1;
    chk(nm, rdData, exp);
  endtask

  initial begin
    rst = 0; ce = 0; we = 0; addr = 0; wtData = 0;
    m_reset();
    #12;
    rd_chk("rst_ctrl", 32'h0, 32'h0);
    rd_chk("rst_load", 32'h4, 32'hFFFF_FFFF);
    rd_chk("rst_count", 32'h8, 32'h0);
    rd_chk("rst_status", 32'hC, 32'h0);
    chk("rst_intimer", {31'd0, intimer}, 32'h0);
    #2 rst = 1;
    chk_en = 1;
    @(posedge clk); #1;

    // Test 1: one-shot countdown 3,2,1,0 then expiry
    wr(32'h4, 32'd3);
    wr(32'h0, 32'h5);
    rd_chk("t1_cnt3", 32'h8, 32'd3); edge_();
    rd_chk("t1_cnt2", 32'h8, 32'd2); edge_();
    rd_chk("t1_cnt1", 32'h8, 32'd1); edge_();
    rd_chk("t1_cnt0", 32'h8, 32'd0);
    chk("t1_int_pre", {31'd0, intimer}, 32'h0);
    edge_();
    rd_chk("t1_flag", 32'hC, 32'h1);
    chk("t1_intimer", {31'd0, intimer}, 32'h1);
    rd_chk("t1_ctrl", 32'h0, 32'h4);
    rd_chk("t1_cnt_hold", 32'h8, 32'd0);

    // Test 2: auto-reload with LOAD=1, W1C between expiries
    wr(32'hC, 32'h1);
    wr(32'h4, 32'd1);
    wr(32'h0, 32'h7);
    edge_(); edge_();
    chk("t2_int_e2", {31'd0, intimer}, 32'h1);
    wr(32'hC, 32'h1);
    chk("t2_int_clr", {31'd0, intimer}, 32'h0);
    wr(32'h0, 32'h7);
    chk("t2_int_re", {31'd0, intimer}, 32'h1);

    // Test 3: W1C lands on the expiry edge; set wins
    edge_();
    rd_chk("t3_cnt0", 32'h8, 32'd0);
    wr(32'hC, 32'h1);
    rd_chk("t3_flag", 32'hC, 32'h1);
    wr(32'h0, 32'h0);
    rd_chk("t3_frozen", 32'h8, 32'd1);
    rd_chk("t3_ctrl", 32'h0, 32'h0);

    // Test 4: unmapped offset and ce=0 behaviour
    rd_chk("t4_rd14", 32'h14, 32'h0);
    wr(32'h14, 32'hFFFF_FFFF);
    rd_chk("t4_ctrl", 32'h0, 32'h0);
    rd_chk("t4_load", 32'h4, 32'd1);
    rd_chk("t4_count", 32'h8, 32'd1);
    ce = 0; we = 0; addr = 32'h4; #1;
    chk("t4_ce0", rdData, 32'h0);

    // Test 5: asynchronous reset mid-count
    wr(32'h4, 32'd100);
    wr(32'h0, 32'h5);
    repeat (10) edge_();
    rd_chk("t5_running", 32'h8, 32'd90);
    rst = 0; m_reset();
    rd_chk("t5_load", 32'h4, 32'hFFFF_FFFF);
    rd_chk("t5_count", 32'h8, 32'h0);
    rd_chk("t5_ctrl", 32'h0, 32'h0);
    chk("t5_intimer", {31'd0, intimer}, 32'h0);
    #1 rst = 1;
    edge_(); edge_();
    rd_chk("t5_noflag", 32'hC, 32'h0);

    // Randomized traffic, small LOAD values so expiries are frequent
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [2:0] o;
      r = $urandom_range(0, 9);
      o = 3'($urandom_range(0, 7));
`ifdef BUS_TIMER_PRESCALE_EN
      if (o == 3'd4) o = 3'd5;
`endif
      ce = 0; we = 0;
      addr = {27'($urandom), o, 2'($urandom)};
      wtData = $urandom;
      case (r)
        0, 1, 2, 3, 4: begin ce = 1'($urandom); we = 0; end
        5: begin ce = 1; we = 1; addr[4:2] = 3'd0; wtData[2:0] = 3'($urandom); end
        6: begin ce = 1; we = 1; addr[4:2] = 3'd1; wtData = $urandom_range(0, 6); end
        7: begin ce = 1; we = 1; addr[4:2] = 3'd3; end
        8: begin ce = 1; we = 1; if (o == 3'd1) wtData = $urandom_range(0, 9); end
        default: begin ce = 0; we = 1; end
      endcase
      edge_();
      if (i % 500 == 250) begin
        #1 rst = 0; m_reset();
        #1 rst = 1;
      end
    end
    ce = 0; we = 0;

`ifdef BUS_TIMER_PRESCALE_EN
    // Test 6: prescaled ticks; model assumes PRESCALE=0, so per-cycle checks pause
    chk_en = 0;
    #1 rst = 0; #1 rst = 1;
    m_reset();
    @(posedge clk); #1;
    wr(32'h10, 32'd3);
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h1);
    repeat (11) edge_();
    rd_chk("t6_flag11", 32'hC, 32'h0);
    edge_();
    rd_chk("t6_flag12", 32'hC, 32'h1);
`else
    rd_chk("t6_rd10", 32'h10, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter RESET_LOAD, default 32'hFFFF_FFFF, meaning the LOAD register value after reset.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ce  input  1  bus select from the memory/IO decoder.
REQ-005 SHALL have port we  input  1  write strobe; write when ce=1 and we=1, read when ce=1 and we=0.
REQ-006 SHALL have port addr  input  32  byte address; only addr[4:2] decoded.
REQ-007 SHALL have port wtData  input  32  write data.
REQ-008 SHALL have port rdData  output  32  read data, combinational.
REQ-009 SHALL have port intimer  output  1  timer interrupt request to CPU intr[0], level-sensitive.

Function
REQ-010 SHALL map registers: 0x00 CTRL, 0x04 LOAD, 0x08 COUNT (read-only), 0x0C STATUS, 0x10 PRESCALE (only with macro).
REQ-011 CTRL SHALL hold bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable); bits 31:3 read 0.
REQ-012 STATUS bit0 FLAG SHALL be write-1-to-clear; writing 0 has no effect.
REQ-013 Writes SHALL take effect at the clock edge in which ce=1 and we=1.
REQ-014 rdData SHALL be the selected register when ce=1 and we=0, else 32'h0; unmapped offsets SHALL read 0, and writes to them SHALL be ignored.
REQ-015 State machine SHALL have states IDLE (EN=0) and RUN (EN=1).
REQ-016 IDLE->RUN: write CTRL with EN=1 while EN=0 SHALL load COUNT<=LOAD in the same edge.
REQ-017 RUN: on each tick, COUNT SHALL decrement by 1 when COUNT!=0.
REQ-018 RUN with tick and COUNT==0: FLAG<=1; if AUTO=1, COUNT<=LOAD and stay RUN; else EN<=0 and go to IDLE with COUNT held at 0.
REQ-019 Expiry period SHALL be LOAD+1 ticks; LOAD=0 SHALL expire on every tick.
REQ-020 Writing LOAD in IDLE SHALL also copy the value into COUNT; writing LOAD in RUN SHALL affect the next reload only.
REQ-021 Writing CTRL with EN=0 in RUN SHALL stop the count with COUNT frozen.
REQ-022 Simultaneous expiry and STATUS W1C in the same edge: set SHALL win, and FLAG SHALL remain 1.
REQ-023 intimer SHALL equal FLAG & IE, driven from registers only, so it asserts 1 cycle after the expiring edge.
REQ-024 COUNT arithmetic SHALL be unsigned 32-bit and SHALL never wrap below 0.

Reset
REQ-025 rst=0 SHALL asynchronously force: CTRL=0, LOAD=RESET_LOAD, COUNT=0, FLAG=0, PRESCALE=0, prescaler counter=0, intimer=0, state IDLE.
REQ-026 Reset asserted mid-count SHALL abandon the count immediately, with no FLAG set on release.

Configuration
REQ-027 With macro BUS_TIMER_PRESCALE_EN defined: an 8-bit PRESCALE register at 0x10 SHALL apply, with a tick every PRESCALE+1 clocks in RUN; the prescaler SHALL clear on IDLE->RUN.
REQ-028 Without BUS_TIMER_PRESCALE_EN: tick SHALL be every clock in RUN, and 0x10 SHALL be unmapped (reads 0).

Structure
REQ-029 Package timer_pkg SHALL hold register offsets, CTRL/STATUS bit indices, and the state enum.
REQ-030 Sub-module timer_prescaler (clk, rst, clr, en, div[7:0] -> tick) SHALL be instantiated only under BUS_TIMER_PRESCALE_EN.

Verification
REQ-031 Test 1: LOAD=3, CTRL=0x5 -> COUNT reads 3,2,1,0; FLAG=1 and intimer=1 on the cycle after COUNT=0 is consumed; EN reads 0.
REQ-032 Test 2: LOAD=1, CTRL=0x7 -> FLAG sets every 2 cycles; after W1C STATUS=1, intimer deasserts next cycle and reasserts 2 cycles later.
REQ-033 Test 3: W1C STATUS written on the exact expiry edge -> FLAG reads 1 afterwards.
REQ-034 Test 4: read 0x14 -> 0; write 0x14 with 0xFFFFFFFF -> CTRL/LOAD/COUNT unchanged; ce=0 read -> rdData=0.
REQ-035 Test 5: LOAD=100, run 10 cycles, pulse rst=0 mid-cycle -> all registers immediately reset; LOAD reads RESET_LOAD; intimer=0.
REQ-036 Test 6 (macro on): PRESCALE=3, LOAD=2, CTRL=0x1 -> FLAG sets 12 clocks after enable.
